// File: rtl/and4_reduce_stream_pkg.sv
// Shared definitions for the AND-reduce stream block.
//   state_e          : control FSM states (ACCUM collects beats, HOLD presents a result)
//   DEF_WIDTH        : default data word width
//   DEF_CNT_WIDTH    : default beat-counter width
package and4_reduce_stream_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_CNT_WIDTH = 4;

endpackage

// File: rtl/and4_reduce_stream_if.sv
// Stream bus for the AND-reduce block: an input beat channel (I/I_valid/I_last,
// I_ready) and a result channel (O/O_count/O_valid, O_ready).
//   slave  : the reduce block (consumes beats, produces results)
//   master : the upstream/downstream side (tb or surrounding logic)
interface and4_reduce_stream_if #(
  parameter int width     = and4_reduce_stream_pkg::DEF_WIDTH,
  parameter int cnt_width = and4_reduce_stream_pkg::DEF_CNT_WIDTH
);
  logic [width-1:0]     I;
  logic                 I_valid;
  logic                 I_last;
  logic                 I_ready;
  logic [width-1:0]     O;
  logic [cnt_width-1:0] O_count;
  logic                 O_valid;
  logic                 O_ready;

  modport slave (
    input  I, I_valid, I_last, O_ready,
    output I_ready, O, O_count, O_valid
  );

  modport master (
    output I, I_valid, I_last, O_ready,
    input  I_ready, O, O_count, O_valid
  );
endinterface

// File: rtl/coreir_and.sv
// Combinational bitwise AND of two words.
//   in0, in1 : operands (width bits)
//   out      : in0 & in1
module coreir_and #(
  parameter int width = 4
) (
  input  logic [width-1:0] in0,
  input  logic [width-1:0] in1,
  output logic [width-1:0] out
);
  assign out = in0 & in1;
endmodule

// File: rtl/and4_reduce_stream.sv
// Frame-wise AND reduction. Beats accepted in ACCUM are ANDed into an
// accumulator and counted (saturating). The beat flagged I_last closes the
// frame: the reduced word and beat count are registered, and the block sits
// in HOLD presenting them until the downstream takes the result.
//   CLK         : clock, rising edge
//   ASYNCRESETN : asynchronous active-low reset
//   bus         : stream interface (slave side)
module and4_reduce_stream
  import and4_reduce_stream_pkg::*;
#(
  parameter int width     = DEF_WIDTH,
  parameter int cnt_width = DEF_CNT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  and4_reduce_stream_if.slave  bus
);

  state_e               state_q, state_d;
  logic [width-1:0]     acc_q, acc_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic [width-1:0]     o_q, o_d;
  logic [cnt_width-1:0] ocnt_q, ocnt_d;

  logic [width-1:0]     and_w;
  logic [cnt_width-1:0] cnt_inc;
  logic                 accept;

  coreir_and #(.width(width)) u_and (
    .in0 (acc_q),
    .in1 (bus.I),
    .out (and_w)
  );

  // Count clamps at all-ones; the AND path keeps running regardless.
  assign cnt_inc = (cnt_q == {cnt_width{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign accept  = (state_q == ACCUM) && bus.I_valid;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= ACCUM;
      acc_q   <= {width{1'b1}};
      cnt_q   <= '0;
      o_q     <= '0;
      ocnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      ocnt_q  <= ocnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    ocnt_d  = ocnt_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (bus.I_last) begin
            // Close the frame and re-arm the accumulator on the same edge.
            o_d     = and_w;
            ocnt_d  = cnt_inc;
            acc_d   = {width{1'b1}};
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            acc_d = and_w;
            cnt_d = cnt_inc;
          end
        end
      end
      HOLD: begin
        if (bus.O_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  assign bus.I_ready = (state_q == ACCUM);
  assign bus.O_valid = (state_q == HOLD);
  assign bus.O       = o_q;
  assign bus.O_count = ocnt_q;

endmodule
